inc_counter: RTL and testbench

//  Parametrised registered incrementer/program counter, next generation of the 16-bit inc unit.

---
 rtl/inc_counter_pkg.sv | 5 +
 rtl/inc_counter_inc_n.sv | 11 +
 rtl/inc_counter.sv | 73 +++++++
 tb/tb_inc_counter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/inc_counter_pkg.sv
// inc_counter_pkg: shared FSM state and action encodings for inc_counter.
package inc_counter_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_SAT = 1'b1} state_e;
  typedef enum logic [1:0] {ACT_HOLD, ACT_LOAD, ACT_INC, ACT_DEC} act_e;
endpackage

// File: rtl/inc_counter_inc_n.sv
// inc_n: combinational WIDTH-bit adder of a + b + cin, returning {ovf, sum}.
module inc_n #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH:0]   sum_o
);
  assign sum_o = {1'b0, a_i} + {1'b0, b_i} + (WIDTH+1)'(cin_i);
endmodule

// File: rtl/inc_counter.sv
// inc_counter: registered incrementer/PC with load, wrap or saturate, overflow pulse.
// Optional decrement port 'dec' enabled by macro INC_COUNTER_DEC_EN.
module inc_counter
  import inc_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned STEP      = 1,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] entrada,
  input  logic             inc,
  input  logic             carry_in,
`ifdef INC_COUNTER_DEC_EN
  input  logic             dec,
`endif
  output logic [WIDTH-1:0] saida,
  output logic             carry_out,
  output logic             sat
);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VAL);
  state_e           state_q, state_d;
  act_e             act;
  logic [WIDTH-1:0] saida_q, saida_d;
  logic             carry_q, carry_d, dec_w, ovf, is_dec;
  logic [WIDTH:0]   sum;
`ifdef INC_COUNTER_DEC_EN
  assign dec_w = dec;
`else
  assign dec_w = 1'b0;
`endif
  assign act    = load ? ACT_LOAD : inc ? ACT_INC : dec_w ? ACT_DEC : ACT_HOLD;
  assign is_dec = (act == ACT_DEC);
  // decrement is saida + ~STEP + !carry_in; a missing carry-out means borrow
  inc_n #(.WIDTH(WIDTH)) u_inc (
    .a_i  (saida_q),
    .b_i  (is_dec ? ~STEP_W : STEP_W),
    .cin_i(is_dec ? ~carry_in : carry_in),
    .sum_o(sum)
  );
  assign ovf = is_dec ^ sum[WIDTH];
  always_comb begin
    saida_d = saida_q;
    carry_d = 1'b0;
    state_d = state_q;
    if (act == ACT_LOAD) begin
      saida_d = entrada;
      state_d = ST_RUN;
    end else if (act != ACT_HOLD && state_q == ST_RUN) begin
      carry_d = ovf;
      saida_d = (ovf && SATURATE) ? {WIDTH{!is_dec}} : sum[WIDTH-1:0];
      state_d = (ovf && SATURATE) ? ST_SAT : ST_RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      saida_q <= RST_W;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      saida_q <= saida_d;
      carry_q <= carry_d;
    end
  end
  assign saida     = saida_q;
  assign carry_out = carry_q;
  assign sat       = (state_q == ST_SAT);
endmodule

// File: tb/tb_inc_counter.sv
// tb_inc_counter: directed + random checks of three inc_counter configurations
// against an arithmetic reference model.
module tb_inc_counter;
  logic clk = 1'b0;
  logic r = 1'b0, l = 1'b0, i = 1'b0, c = 1'b0, d = 1'b0;
  logic [15:0] e = '0;
  logic [15:0] so_w, so_s;
  logic [7:0]  so_p;
  logic co_w, co_s, co_p, st_w, st_s, st_p;
  int errors = 0, checks = 0;
  longint mv[3], mw[3], ms[3], mr[3];
  bit mc[3], mt[3], msat[3];

  always #5 clk = ~clk;

  inc_counter #(.WIDTH(16), .STEP(1), .SATURATE(1'b0), .RESET_VAL(0)) u_w (
    .clk(clk), .reset(r), .load(l), .entrada(e), .inc(i), .carry_in(c),
`ifdef INC_COUNTER_DEC_EN
    .dec(d),
`endif
    .saida(so_w), .carry_out(co_w), .sat(st_w));
  inc_counter #(.WIDTH(16), .STEP(1), .SATURATE(1'b1), .RESET_VAL(0)) u_s (
    .clk(clk), .reset(r), .load(l), .entrada(e), .inc(i), .carry_in(c),
`ifdef INC_COUNTER_DEC_EN
    .dec(d),
`endif
    .saida(so_s), .carry_out(co_s), .sat(st_s));
  inc_counter #(.WIDTH(8), .STEP(5), .SATURATE(1'b1), .RESET_VAL('hA5)) u_p (
    .clk(clk), .reset(r), .load(l), .entrada(e[7:0]), .inc(i), .carry_in(c),
`ifdef INC_COUNTER_DEC_EN
    .dec(d),
`endif
    .saida(so_p), .carry_out(co_p), .sat(st_p));

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    for (int k = 0; k < 3; k++) begin
      longint top = longint'(1) << mw[k];
      longint s;
      if (r) begin
        mv[k] = mr[k]; mc[k] = 0; mt[k] = 0;
      end else if (l) begin
        mv[k] = longint'(e) % top; mc[k] = 0; mt[k] = 0;
      end else if (i || d) begin
        mc[k] = 0;
        if (!mt[k]) begin
          s = i ? mv[k] + ms[k] + longint'(c) : mv[k] - ms[k] - longint'(c);
          if (s >= top || s < 0) begin
            mc[k] = 1;
            if (msat[k]) begin
              mv[k] = i ? top - 1 : 0; mt[k] = 1;
            end else mv[k] = i ? s - top : s + top;
          end else mv[k] = s;
        end
      end else mc[k] = 0;
    end
  endtask

  task automatic cyc(input bit rr, input bit ll, input logic [15:0] ee, input bit ii,
                     input bit cc, input bit dd);
    r = rr; l = ll; e = ee; i = ii; c = cc; d = dd;
    @(posedge clk);
    model();
    #1;
    chk("wrap_saida", longint'(so_w), mv[0]);
    chk("wrap_cout",  longint'(co_w), longint'(mc[0]));
    chk("wrap_sat",   longint'(st_w), longint'(mt[0]));
    chk("sat_saida",  longint'(so_s), mv[1]);
    chk("sat_cout",   longint'(co_s), longint'(mc[1]));
    chk("sat_sat",    longint'(st_s), longint'(mt[1]));
    chk("p8_saida",   longint'(so_p), mv[2]);
    chk("p8_cout",    longint'(co_p), longint'(mc[2]));
    chk("p8_sat",     longint'(st_p), longint'(mt[2]));
  endtask

  initial begin
    mw = '{16, 16, 8}; ms = '{1, 1, 5}; mr = '{0, 0, 'hA5}; msat = '{0, 1, 1};
    cyc(1, 0, 16'h0000, 0, 0, 0);
    chk("reset_zero", longint'(so_w), 0);
    chk("reset_p8", longint'(so_p), 'hA5);
    repeat (3) cyc(0, 0, 16'h5555, 0, 1, 0);
    cyc(0, 1, 16'h0001, 0, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);
    chk("inc_c0", longint'(so_w), 'h0002);
    cyc(0, 0, 16'h0000, 1, 1, 0);
    chk("inc_c1", longint'(so_w), 'h0004);
    cyc(0, 1, 16'hFFFF, 0, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);
    chk("wrap_to0", longint'(so_w), 0);
    chk("wrap_pulse", longint'(co_w), 1);
    cyc(0, 0, 16'h0000, 0, 0, 0);
    chk("pulse_end", longint'(co_w), 0);
    cyc(0, 1, 16'hFFFE, 0, 0, 0);
    cyc(0, 0, 16'h0000, 1, 1, 0);
    chk("sat_ones", longint'(so_s), 'hFFFF);
    chk("sat_flag", longint'(st_s), 1);
    cyc(0, 0, 16'h0000, 1, 1, 0);
    cyc(0, 1, 16'h0010, 0, 0, 0);
    chk("sat_exit", longint'(st_s), 0);
    cyc(0, 1, 16'hFFFE, 0, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);
    chk("ones_no_ovf", longint'(co_s), 0);
    cyc(1, 1, 16'h4321, 1, 1, 0);
    cyc(0, 1, 16'h1234, 1, 1, 0);
    chk("load_over_inc", longint'(so_w), 'h1234);
`ifdef INC_COUNTER_DEC_EN
    cyc(0, 1, 16'h0000, 0, 0, 0);
    cyc(0, 0, 16'h0000, 0, 0, 1);
    chk("dec_wrap", longint'(so_w), 'hFFFF);
    cyc(0, 0, 16'h0000, 1, 0, 1);
    chk("inc_wins", longint'(so_w), 0);
`endif
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ev;
      int sel = $urandom_range(0, 3);
      ev = sel == 0 ? 16'hFFFF - 16'($urandom_range(0, 12)) :
           sel == 1 ? 16'($urandom_range(0, 12)) : 16'($urandom);
      cyc($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, ev,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
`ifdef INC_COUNTER_DEC_EN
          $urandom_range(0, 1) == 1
`else
          1'b0
`endif
          );
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
